// File: rtl/core_alu_muldiv_pkg.sv
// Shared op codes, FSM states and op classification for the execute-stage ALU.
package core_alu_muldiv_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_ORR = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_SHL = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_ADD = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_ASR = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_MOD = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/core_muldiv_seq.sv
// Iterative datapath: MSB-first shift-add multiply and restoring divide, one bit per step.
// result is the value after the current step, so the top can capture it on the last step.
module core_muldiv_seq
  import core_alu_muldiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [W-1:0]  hi, lo, dv;
  logic [W-1:0]  hi_n, lo_n, diff;
  logic [W:0]    trial;

  // hi is the product accumulator / partial remainder; lo shifts out the
  // multiplier or dividend bits and shifts in quotient bits.
  always_comb begin
    hi_n  = hi;
    lo_n  = lo;
    trial = {hi, lo[W-1]};
    diff  = trial[W-1:0] - dv;
    if (op_q == ALU_MUL) begin
      hi_n = {hi[W-2:0], 1'b0} + (lo[W-1] ? dv : '0);
      lo_n = {lo[W-2:0], 1'b0};
    end else if (trial >= {1'b0, dv}) begin
      // A zero divisor always lands here: quotient fills with ones and the
      // remainder ends up holding the dividend.
      hi_n = diff;
      lo_n = {lo[W-2:0], 1'b1};
    end else begin
      hi_n = trial[W-1:0];
      lo_n = {lo[W-2:0], 1'b0};
    end
  end

  assign last   = (cnt == CW'(W - 1));
  assign result = (op_q == ALU_DIV) ? lo_n : hi_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= ALU_MUL;
      hi   <= '0;
      lo   <= '0;
      dv   <= '0;
    end else if (load) begin
      cnt  <= '0;
      op_q <= op;
      hi   <= '0;
      lo   <= a;
      dv   <= b;
    end else if (step) begin
      cnt  <= cnt + 1'b1;
      hi   <= hi_n;
      lo   <= lo_n;
    end
  end

endmodule

// File: rtl/core_alu_muldiv.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus W+1-cycle mul/div/mod.
// Owns accept, writeback registers, busy and the pending-destination RAW mask.
module core_alu_muldiv
  import core_alu_muldiv_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 8,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic [IMM_W-1:0]         imm,
  input  logic                     uses_imm,
  output logic                     busy,
  output logic                     wb_ready,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [W-1:0]             wb_value,
  output logic [NREGS-1:0]         raw_mask
);

  localparam int SHW = $clog2(W);

  state_e                   state, state_n;
  logic [$clog2(NREGS)-1:0] lat_rd;
  logic [W-1:0]             bp, alu_res, seq_res;
  logic [SHW-1:0]           shamt;
  logic                     big, accept, multi, seq_last;

  assign bp     = uses_imm ? W'(imm) : b;
  assign busy   = (state != IDLE);
  assign accept = start && (state == IDLE);
  assign multi  = is_multi(op);
  assign shamt  = bp[SHW-1:0];
  assign big    = |bp[W-1:SHW];

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_AND: alu_res = a & bp;
      ALU_ORR: alu_res = a | bp;
      ALU_XOR: alu_res = a ^ bp;
      ALU_ADD: alu_res = a + bp;
      ALU_SUB: alu_res = a - bp;
      ALU_SHL: alu_res = big ? '0 : (a << shamt);
      ALU_SHR: alu_res = big ? '0 : (a >> shamt);
      ALU_ASR: alu_res = big ? {W{a[W-1]}} : $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  core_muldiv_seq #(.W(W)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && multi),
    .step   (state == ITER),
    .op     (op),
    .a      (a),
    .b      (bp),
    .last   (seq_last),
    .result (seq_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && multi) state_n = ITER;
      ITER:    if (seq_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The iterative result is captured on the final step so the pulse lands in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ready <= 1'b0;
      wb_rd    <= '0;
      wb_value <= '0;
      lat_rd   <= '0;
    end else begin
      wb_ready <= 1'b0;
      if (accept && multi) begin
        lat_rd <= rd;
      end else if (accept) begin
        wb_ready <= 1'b1;
        wb_rd    <= rd;
        wb_value <= alu_res;
      end else if ((state == ITER) && seq_last) begin
        wb_ready <= 1'b1;
        wb_rd    <= lat_rd;
        wb_value <= seq_res;
      end
    end
  end

  always_comb begin
    raw_mask = '0;
    if (busy)       raw_mask = NREGS'(1) << lat_rd;
    else if (start) raw_mask = NREGS'(1) << rd;
  end

endmodule

// File: tb/tb_core_alu_muldiv.sv
// Directed-vector bench for core_alu_muldiv at W=16 with immediate-assertion checks.
module tb_core_alu_muldiv;
  import core_alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [3:0]  rd = 4'd0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic [7:0]  imm = 8'h0;
  logic        uses_imm = 1'b0;
  logic        busy, wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_value, raw_mask;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  core_alu_muldiv #(.W(16), .IMM_W(8), .NREGS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rd       (rd),
    .a        (a),
    .b        (b),
    .imm      (imm),
    .uses_imm (uses_imm),
    .busy     (busy),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_value (wb_value),
    .raw_mask (raw_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle op issued at a negedge; result checked one cycle later.
  task automatic sc(input string tag, input logic [3:0] o, input logic [15:0] aa,
                    input logic [15:0] bb, input logic [7:0] im, input logic ui,
                    input logic [15:0] exp);
    start = 1'b1; op = o; rd = 4'd1; a = aa; b = bb; imm = im; uses_imm = ui;
    @(negedge clk);
    chk({tag, "_rdy"}, wb_ready, 1);
    chk(tag, wb_value, exp);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_multi(input string tag, input logic [3:0] o, input logic [3:0] r,
                           input logic [15:0] aa, input logic [15:0] bb,
                           input logic [15:0] exp, input bit inject);
    int nwb, lat, nbusy, mask_bad;
    logic [15:0] val;
    logic [3:0]  wrd;
    nwb = 0; lat = 0; nbusy = 0; mask_bad = 0; val = 16'h0; wrd = 4'h0;
    start = 1'b1; op = o; rd = r; a = aa; b = bb; uses_imm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) nbusy++;
      if (raw_mask !== (busy ? (16'(1) << r) : 16'h0)) mask_bad++;
      if (wb_ready) begin
        nwb++; lat = c; val = wb_value; wrd = wb_rd;
      end
      if (inject && c == 3) begin
        start = 1'b1; op = ALU_ADD; rd = 4'd9; a = 16'h1111; b = 16'h2222;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, 17);
    chk({tag, "_nwb"}, nwb, 1);
    chk({tag, "_nbusy"}, nbusy, 17);
    chk({tag, "_mask"}, mask_bad, 0);
    chk({tag, "_val"}, val, exp);
    chk({tag, "_rd"}, wrd, r);
    chk({tag, "_hold"}, wb_value, exp);
  endtask

  initial begin
    int nwb_rst;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wb_ready", wb_ready, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_raw_mask", raw_mask, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with immediate, including RAW mask at issue
    start = 1'b1; op = ALU_ADD; rd = 4'd3; a = 16'hFFFF; b = 16'h1234; imm = 8'h02; uses_imm = 1'b1;
    #1;
    chk("add_issue_mask", raw_mask, 16'h0008);
    @(negedge clk);
    start = 1'b0;
    chk("add_rdy", wb_ready, 1);
    chk("add_val", wb_value, 16'h0001);
    chk("add_rd", wb_rd, 3);
    chk("add_busy", busy, 0);
    @(negedge clk);
    chk("add_pulse_end", wb_ready, 0);
    chk("add_hold", wb_value, 16'h0001);

    // Back-to-back single-cycle ops
    sc("asr_big", ALU_ASR, 16'h8000, 16'd20, 8'h00, 1'b0, 16'hFFFF);
    sc("shl_w",   ALU_SHL, 16'h0001, 16'd16, 8'h00, 1'b0, 16'h0000);
    sc("shr_15",  ALU_SHR, 16'h8000, 16'd15, 8'h00, 1'b0, 16'h0001);
    sc("shr_w",   ALU_SHR, 16'h8000, 16'd16, 8'h00, 1'b0, 16'h0000);
    sc("asr_4",   ALU_ASR, 16'h8000, 16'd4,  8'h00, 1'b0, 16'hF800);
    sc("and",     ALU_AND, 16'hF0F0, 16'hFF00, 8'h00, 1'b0, 16'hF000);
    sc("orr_imm", ALU_ORR, 16'h00F0, 16'hFFFF, 8'h0F, 1'b1, 16'h00FF);
    sc("sub_wrap", ALU_SUB, 16'h0000, 16'h0001, 8'h00, 1'b0, 16'hFFFF);
    sc("undef",   4'd12,   16'h1234, 16'h5678, 8'h00, 1'b0, 16'h0000);
    start = 1'b0;
    @(negedge clk);

    run_multi("mul",     ALU_MUL, 4'd5, 16'd300,  16'd300, 16'h5F90, 1'b1);
    run_multi("div",     ALU_DIV, 4'd6, 16'd1000, 16'd7,   16'd142,  1'b0);
    run_multi("mod",     ALU_MOD, 4'd7, 16'd1000, 16'd7,   16'd6,    1'b0);
    run_multi("div0",    ALU_DIV, 4'd8, 16'h1234, 16'd0,   16'hFFFF, 1'b0);
    run_multi("mod0",    ALU_MOD, 4'd9, 16'h1234, 16'd0,   16'h1234, 1'b0);

    // Reset in the middle of a divide
    start = 1'b1; op = ALU_DIV; rd = 4'd2; a = 16'd1000; b = 16'd7; uses_imm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mask", raw_mask, 0);
    chk("rst_mid_wb", wb_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nwb_rst = 0;
    repeat (20) begin
      @(negedge clk);
      if (wb_ready) nwb_rst++;
    end
    chk("rst_mid_no_wb", nwb_rst, 0);
    sc("xor_after_rst", ALU_XOR, 16'h00FF, 16'h0F0F, 8'h00, 1'b0, 16'h0FF0);
    start = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/core_alu_muldiv.md
Name: core_alu_muldiv

Overview:
Parametrised ALU for the execute stage. All single-cycle logic and shift ops complete with 1-cycle latency. It adds an iterative multiplier and a restoring divider (quotient and remainder) that take W+1 cycles.
- Produces one writeback line per accepted op.
- Provides a RAW mask of the pending destination register.
- Exposes a busy signal so issue logic can stall.

Parameters:
W, 16, datapath width in bits (>=4, power of two)
IMM_W, 8, immediate width; zero-extended to W
NREGS, 16, register count; width of raw_mask; rd width is $clog2(NREGS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  issue strobe; accepted only when busy=0
op  in  4  operation code (ALU_* constants in package)
rd  in  $clog2(NREGS)  destination register
a  in  W  operand A
b  in  W  operand B
imm  in  IMM_W  immediate
uses_imm  in  1  1: operand B' = zero-extended imm, else b
busy  out  1  multi-cycle op in flight; start ignored
wb_ready  out  1  one-cycle pulse: wb_rd/wb_value valid
wb_rd  out  $clog2(NREGS)  writeback register
wb_value  out  W  writeback value
raw_mask  out  NREGS  one-hot of pending rd, else 0

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, wb_ready=0, wb_rd=0, wb_value=0, raw_mask=0.
  - FSM enters IDLE; counter cleared.
  - Reset mid-iteration aborts the op with no writeback.
- Accept: start=1 and FSM in IDLE. When busy=1, start has no effect: not queued, no wb, no state change.
- B' = uses_imm ? imm zero-extended : b. B' is used by every op.
- Single-cycle ops (latency 1): ALU_AND, ALU_ORR, ALU_XOR, ALU_ADD, ALU_SUB (mod 2^W), ALU_SHL, ALU_SHR (logical), ALU_ASR (arithmetic).
  - Shift amount is B' taken as an unsigned value.
  - Amount >= W gives 0 for SHL/SHR, and gives all bits = a[W-1] for ASR.
  - Result is registered; wb_ready=1 in the cycle after accept. busy stays 0, so ops can issue back-to-back every cycle.
- Multi-cycle ops: ALU_MUL (low W bits of a*B', unsigned shift-add), ALU_DIV (unsigned quotient), ALU_MOD (unsigned remainder).
  - On accept, latch a, B', op and rd; go to ITER with counter=0.
  - busy=1 from the cycle after accept through the cycle wb_ready pulses.
  - ITER: one bit per cycle, counter increments. When counter=W-1, go to DONE.
  - DONE: register the result, wb_ready=1 for one cycle, busy=0 from the next cycle, return to IDLE.
  - Accept to wb_ready is W+1 cycles.
  - start is not accepted in DONE.
- Divide by zero (B'=0): DIV gives all ones; MOD gives a. Full latency still applies.
- Undefined op codes: treated as single-cycle, wb_value=0, wb_ready still pulses.
- wb_rd always equals the rd latched at accept. Outputs hold their value between pulses.
- raw_mask (combinational):
  - onehot(rd) when start=1 and IDLE.
  - onehot(latched rd) while busy=1.
  - Otherwise 0.
- FSM: IDLE -> (accept multi-cycle op) ITER -> (counter=W-1) DONE -> IDLE.
  - Single-cycle ops leave the FSM in IDLE.

Decomposition:
- Shared package holds:
  - ALU_* op constants (AND 0, ORR 1, XOR 2, SHL 3, SHR 4, ADD 5, SUB 6, ASR 7, MUL 8, DIV 9, MOD 10).
  - The FSM state enum (IDLE/ITER/DONE).
- One sub-module, core_muldiv_seq: iterative shift-add / restoring-divide datapath with counter. The top owns the single-cycle path, the accept logic, the writeback registers and raw_mask.

Test Plan:
(W=16 throughout)
- ADD a=0xFFFF, uses_imm=1, imm=0x02, rd=3 -> next cycle wb_ready=1, wb_value=0x0001, wb_rd=3, busy stays 0.
- ASR a=0x8000, b=20 -> wb_value=0xFFFF; SHL a=0x0001, b=16 -> 0x0000; SHR a=0x8000, b=15 -> 0x0001.
- MUL a=300, b=300, rd=5 -> busy high 17 cycles, raw_mask=0x0020 throughout, wb_ready 17 cycles after accept, wb_value=0x5F90.
- DIV a=1000, b=7 -> 142; MOD same operands -> 6; DIV a=0x1234, b=0 -> 0xFFFF; MOD same -> 0x1234.
- Issue ADD on the 3rd cycle of a MUL busy window -> ignored: exactly one wb_ready, carrying the MUL result.
- Assert rst_n=0 at iteration 8 of a DIV -> busy=0, raw_mask=0, no wb_ready afterwards; a fresh XOR 0x00FF^0x0F0F gives 0x0FF0.
